intensity_lut_generator: RTL and testbench

Produces the 16-bit per-fragment `intensity` operand consumed by the color interpolation stage, for fog and other depth-driven blends. Each depth value is mapped through a 33-knot piecewise-linear table loaded at runtime. The block sits between the fragment depth stream and the color interpolator and forwards a user sideband, such as fragment colors, aligned with each result. It is fully pipelined with valid/ready backpressure on both the depth and intensity streams.

---
 rtl/intensity_lut_generator.sv | 179 +++++++++++++++++
 tb/tb_intensity_lut_generator.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intensity_lut_generator.sv
// intensity_lut_generator: maps a 16-bit depth through a 33-knot
// piecewise-linear table. The table is loaded at runtime. A user sideband
// travels with each depth through a three-stage, back-pressured pipeline.
module intensity_lut_generator #(
  parameter int USER_WIDTH = 64
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  s_lut_valid,
  output logic                  s_lut_ready,
  input  logic                  s_lut_last,
  input  logic [15:0]           s_lut_data,
  input  logic                  s_depth_valid,
  output logic                  s_depth_ready,
  input  logic [15:0]           s_depth_data,
  input  logic [USER_WIDTH-1:0] s_depth_user,
  output logic                  m_intensity_valid,
  input  logic                  m_intensity_ready,
  output logic [15:0]           m_intensity_data,
  output logic [USER_WIDTH-1:0] m_intensity_user
);

  typedef enum logic {
    IDLE,
    LOADING
  } state_t;

  localparam int          NUM_KNOTS = 33;
  localparam logic [5:0]  ADDR_SAT  = 6'd33;

  state_t      state, next_state;
  logic [5:0]  wr_addr;
  logic [15:0] knot [0:NUM_KNOTS-1];

  logic lut_fire;
  logic depth_fire;
  logic ce;

  // Segment index and the two knot addresses bracketing the segment.
  logic [5:0] idx_lo;
  logic [5:0] idx_hi;

  // Stage 1: the two bracketing knots, the fraction and the sideband.
  logic                  s1_valid;
  logic [15:0]           s1_k0;
  logic [15:0]           s1_k1;
  logic [10:0]           s1_frac;
  logic [USER_WIDTH-1:0] s1_user;

  // Stage 2: the base knot and the signed slope-times-fraction product.
  logic                  s2_valid;
  logic [15:0]           s2_base;
  logic signed [27:0]    s2_prod;
  logic [USER_WIDTH-1:0] s2_user;

  logic signed [16:0] diff;
  logic signed [27:0] diff_ext;
  logic signed [27:0] frac_ext;
  logic signed [27:0] prod;

  // The table is writable whenever the block is out of reset.
  assign s_lut_ready = resetn;
  assign lut_fire    = s_lut_valid && s_lut_ready;

  // The whole pipeline moves only when the output register is free or being drained.
  assign ce         = !m_intensity_valid || m_intensity_ready;
  assign depth_fire = s_depth_valid && s_depth_ready;

  assign idx_lo = {1'b0, s_depth_data[15:11]};
  assign idx_hi = idx_lo + 6'd1;

  // Load FSM state register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Load FSM next state and the depth-side ready. A pending table beat wins over depth.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    next_state    = state;
    s_depth_ready = 1'b0;
    if (lut_fire) begin
      next_state = s_lut_last ? IDLE : LOADING;
    end
    if (resetn && ce && (state == IDLE) && !s_lut_valid) begin
      s_depth_ready = 1'b1;
    end
  end

  // Write pointer: saturates past the last knot, and rewinds on the final beat.
  always_ff @(posedge aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) begin
      wr_addr <= '0;
    end else if (lut_fire) begin
      if (s_lut_last) begin
        wr_addr <= '0;
      end else if (wr_addr != ADDR_SAT) begin
        wr_addr <= wr_addr + 6'd1;
      end
    end
  end

  // Knot table: reset to 1.0 everywhere. Beats past the last knot are dropped.
  always_ff @(posedge aclk) begin
    // NOTE: this table is reset on purpose; an unloaded table must read as full intensity.
    if (!resetn) begin
      for (int k = 0; k < NUM_KNOTS; k++) begin
        knot[k] <= 16'hFFFF;
      end
    end else if (lut_fire && (wr_addr < ADDR_SAT)) begin
      knot[wr_addr] <= s_lut_data;
    end
  end

  // Stage 1 capture. Knots are sampled here, so later loads cannot disturb this fragment.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
    end else if (ce) begin
      s1_valid <= depth_fire;
    end
  end

  // Stage 1 data path.
  always_ff @(posedge aclk) begin
    // NOTE: payload registers need no reset; their valid bit qualifies them.
    if (ce) begin
      s1_k0   <= knot[idx_lo];
      s1_k1   <= knot[idx_hi];
      s1_frac <= s_depth_data[10:0];
      s1_user <= s_depth_user;
    end
  end

  // Signed slope across the segment, multiplied by the unsigned fraction.
  // The magnitude is at most 65535 * 2047, which fits in 28 signed bits.
  assign diff     = $signed({1'b0, s1_k1}) - $signed({1'b0, s1_k0});
  assign diff_ext = {{11{diff[16]}}, diff};
  assign frac_ext = {17'd0, s1_frac};
  assign prod     = diff_ext * frac_ext;

  // Stage 2: register the product and the base knot.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      s2_valid <= 1'b0;
    end else if (ce) begin
      s2_valid <= s1_valid;
    end
  end

  // Stage 2 data path.
  always_ff @(posedge aclk) begin
    if (ce) begin
      s2_base <= s1_k0;
      s2_prod <= prod;
      s2_user <= s1_user;
    end
  end

  // Stage 3: floor-shift the product, add it to the base knot and drive the outputs.
  // The result always lies between the two knots, so the 16-bit truncation is exact.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      m_intensity_valid <= 1'b0;
      m_intensity_data  <= '0;
      m_intensity_user  <= '0;
    end else if (ce) begin
      m_intensity_valid <= s2_valid;
      m_intensity_data  <= s2_base + 16'(s2_prod >>> 11);
      m_intensity_user  <= s2_user;
    end
  end

endmodule

// File: tb/tb_intensity_lut_generator.sv
// Self-checking bench for intensity_lut_generator.
// The stimulus pushes expected results into a scoreboard queue. A negedge
// monitor pops an entry and compares it every time an output is accepted.
module tb_intensity_lut_generator;

  localparam int UW = 64;

  logic          aclk = 1'b0;
  logic          resetn;
  logic          s_lut_valid;
  logic          s_lut_ready;
  logic          s_lut_last;
  logic [15:0]   s_lut_data;
  logic          s_depth_valid;
  logic          s_depth_ready;
  logic [15:0]   s_depth_data;
  logic [UW-1:0] s_depth_user;
  logic          m_intensity_valid;
  logic          m_intensity_ready = 1'b1;
  logic [15:0]   m_intensity_data;
  logic [UW-1:0] m_intensity_user;

  intensity_lut_generator #(.USER_WIDTH(UW)) dut (
    .aclk              (aclk),
    .resetn            (resetn),
    .s_lut_valid       (s_lut_valid),
    .s_lut_ready       (s_lut_ready),
    .s_lut_last        (s_lut_last),
    .s_lut_data        (s_lut_data),
    .s_depth_valid     (s_depth_valid),
    .s_depth_ready     (s_depth_ready),
    .s_depth_data      (s_depth_data),
    .s_depth_user      (s_depth_user),
    .m_intensity_valid (m_intensity_valid),
    .m_intensity_ready (m_intensity_ready),
    .m_intensity_data  (m_intensity_data),
    .m_intensity_user  (m_intensity_user)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the knot table as integers plus a write pointer.
  int model_knot [33];
  int model_addr;

  function automatic void model_reset();
    for (int k = 0; k < 33; k++) model_knot[k] = 16'hFFFF;
    model_addr = 0;
  endfunction

  function automatic void model_load(input logic [15:0] v, input bit last);
    if (model_addr < 33) model_knot[model_addr] = int'(v);
    model_addr = last ? 0 : model_addr + 1;
  endfunction

  // Linear interpolation: base + floor(slope * f / 2048).
  function automatic logic [15:0] model_eval(input logic [15:0] depth);
    int i, f, d, p, q;
    i = int'(depth[15:11]);
    f = int'(depth[10:0]);
    d = model_knot[i + 1] - model_knot[i];
    p = d * f;
    if (p >= 0) q = p / 2048;
    else        q = -((-p + 2047) / 2048);
    return 16'(model_knot[i] + q);
  endfunction

  typedef struct {
    logic [15:0]   data;
    logic [UW-1:0] user;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  // Ready generator: either always ready or a random toggle each cycle.
  bit rand_ready = 1'b0;
  always @(posedge aclk) begin
    #1;
    m_intensity_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor: stall stability, depth ready during a stall, and scoreboard compares.
  logic          held_v = 1'b0;
  logic [15:0]   held_d;
  logic [UW-1:0] held_u;
  always @(negedge aclk) begin
    if (resetn === 1'b1) begin
      if (held_v) begin
        check("stall_valid_held", 64'(m_intensity_valid), 64'd1);
        check("stall_data_stable", 64'(m_intensity_data), 64'(held_d));
        check("stall_user_stable", m_intensity_user, held_u);
      end
      if (m_intensity_valid && !m_intensity_ready) begin
        check("depth_ready_in_stall", 64'(s_depth_ready), 64'd0);
        held_v = 1'b1;
        held_d = m_intensity_data;
        held_u = m_intensity_user;
      end else begin
        held_v = 1'b0;
      end
      if (m_intensity_valid && m_intensity_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("intensity_data", 64'(m_intensity_data), 64'(mon_e.data));
          check("intensity_user", m_intensity_user, mon_e.user);
          // Handshake presented in cycle N; the result is presented in cycle N+3.
          if (mon_e.lat) check("latency", 64'(cyc - mon_e.cyc), 64'd3);
        end
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic send_depth(input logic [15:0] depth, input logic [UW-1:0] user);
    bit ok = 1'b0;
    s_depth_valid = 1'b1;
    s_depth_data  = depth;
    s_depth_user  = user;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge aclk);
      if (s_depth_ready) begin
        ok = 1'b1;
        sb.push_back('{model_eval(depth), user, cyc, !rand_ready});
      end
      @(posedge aclk);
      #1;
    end
    if (!ok) check("depth_accept_timeout", 64'd0, 64'd1);
    s_depth_valid = 1'b0;
  endtask

  task automatic lut_beat(input logic [15:0] v, input bit last);
    bit ok = 1'b0;
    s_lut_valid = 1'b1;
    s_lut_data  = v;
    s_lut_last  = last;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge aclk);
      check("depth_ready_during_load", 64'(s_depth_ready), 64'd0);
      if (s_lut_ready) begin
        ok = 1'b1;
        model_load(v, last);
      end
      @(posedge aclk);
      #1;
    end
    if (!ok) check("lut_accept_timeout", 64'd0, 64'd1);
    s_lut_valid = 1'b0;
    s_lut_last  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 1000 && sb.size() != 0; n++) @(negedge aclk);
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (4) @(posedge aclk);
    #1;
  endtask

  // Reset sequence, with checks on the ready outputs and on the cleared output register.
  task automatic do_reset();
    @(posedge aclk);
    #1;
    resetn = 1'b0;
    @(negedge aclk);
    check("lut_ready_in_reset", 64'(s_lut_ready), 64'd0);
    check("depth_ready_in_reset", 64'(s_depth_ready), 64'd0);
    @(negedge aclk);
    check("reset_out_valid", 64'(m_intensity_valid), 64'd0);
    check("reset_out_data", 64'(m_intensity_data), 64'd0);
    check("reset_out_user", m_intensity_user, 64'd0);
    @(posedge aclk);
    #1;
    resetn = 1'b1;
    model_reset();
    sb.delete();
    @(negedge aclk);
    check("lut_ready_after_reset", 64'(s_lut_ready), 64'd1);
    check("depth_ready_idle_after_reset", 64'(s_depth_ready), 64'd1);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    resetn        = 1'b0;
    s_lut_valid   = 1'b0;
    s_lut_last    = 1'b0;
    s_lut_data    = '0;
    s_depth_valid = 1'b0;
    s_depth_data  = '0;
    s_depth_user  = '0;
    model_reset();

    do_reset();

    // Reset table: every depth maps to full intensity.
    send_depth(16'h0000, {$urandom, $urandom});
    send_depth(16'h7FFF, {$urandom, $urandom});
    send_depth(16'hFFFF, {$urandom, $urandom});
    drain();

    // Linear ramp: knot[i] = i*2048, and knot[32] = 0xFFFF.
    for (int i = 0; i < 32; i++) lut_beat(16'(i * 2048), 1'b0);
    lut_beat(16'hFFFF, 1'b1);
    send_depth(16'h1234, {$urandom, $urandom});
    send_depth(16'hF800, {$urandom, $urandom});
    send_depth(16'hFFFF, {$urandom, $urandom});
    drain();

    // Negative slope: the floor rounding must go toward minus infinity.
    lut_beat(16'hFFFF, 1'b0);
    lut_beat(16'h0000, 1'b1);
    send_depth(16'h0400, {$urandom, $urandom});
    send_depth(16'h0001, {$urandom, $urandom});
    send_depth(16'h0800, {$urandom, $urandom});
    drain();

    // Random table, then back-to-back depths under random backpressure.
    for (int i = 0; i < 33; i++) lut_beat(16'($urandom), i == 32);
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_depth(16'($urandom), {$urandom, $urandom});
    drain();
    for (int i = 0; i < 60; i++) begin
      send_depth(16'($urandom), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
    end
    drain();
    rand_ready = 1'b0;

    // Load during traffic: the in-flight fragment keeps the old table.
    do_reset();
    send_depth(16'h0800, 64'h1111_2222_3333_4444);
    lut_beat(16'h0000, 1'b0);
    @(negedge aclk);
    check("depth_ready_while_loading", 64'(s_depth_ready), 64'd0);
    @(posedge aclk);
    #1;
    lut_beat(16'h1000, 1'b1);
    send_depth(16'h0800, 64'h5555_6666_7777_8888);
    drain();

    // Overlength load: only knots 0..32 take the data; the extra beats are accepted.
    for (int k = 0; k < 40; k++) lut_beat(16'(k * 1111 + 7), k == 39);
    send_depth(16'h0000, {$urandom, $urandom});
    send_depth(16'h2800, {$urandom, $urandom});
    send_depth(16'hF800, {$urandom, $urandom});
    send_depth(16'hFFFF, {$urandom, $urandom});
    send_depth(16'hFC00, {$urandom, $urandom});
    drain();

    // Reset in the middle of a load discards the partial load.
    for (int k = 0; k < 10; k++) lut_beat(16'($urandom), 1'b0);
    do_reset();
    send_depth(16'h0000, {$urandom, $urandom});
    send_depth(16'h5555, {$urandom, $urandom});
    send_depth(16'hFFFF, {$urandom, $urandom});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
